// File: rtl/gpio_cmd_decoder_if.sv
// Register-write handshake between the command decoder and the
// datapath register file.
interface gpio_cmd_decoder_if #(
   parameter int AW = 12
);
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic          wr_ready;

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_data,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_data,
      output wr_ready
   );
endinterface

// File: rtl/gpio_cmd_decoder.sv
// Consumer end of the GPIO command mailbox: buffers command pulses
// and turns them into register writes, commit strobes and error flags.
module gpio_cmd_decoder #(
   parameter int DEPTH = 4,
   parameter int AW    = 12
) (
   input  logic                dst_clk,
   input  logic                dst_rst_n,
   input  logic                wen_dst,
   input  logic [31:0]         wdata_dst,
   gpio_cmd_decoder_if.master  wr,
   output logic                commit,
   output logic [2:0]          err_flags,
   output logic [15:0]         cmd_count,
   output logic                busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LO  = 4'h1;
   localparam logic [3:0] OP_HI  = 4'h2;
   localparam logic [3:0] OP_W16 = 4'h3;
   localparam logic [3:0] OP_CMT = 4'h4;
   localparam logic [3:0] OP_CLR = 4'hF;

   typedef struct packed {
      logic [3:0]    op;
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } cmd_t;

   typedef enum logic {
      S_IDLE,
      S_ISSUE
   } state_e;

   cmd_t          mem_q [DEPTH];
   logic [PW-1:0] wptr_q;
   logic [PW-1:0] rptr_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   state_e        state_q;
   state_e        state_d;
   logic          wr_valid_q;
   logic          wr_valid_d;
   logic [AW-1:0] wr_addr_q;
   logic [AW-1:0] wr_addr_d;
   logic [31:0]   wr_data_q;
   logic [31:0]   wr_data_d;
   logic          commit_q;
   logic          commit_d;
   logic [2:0]    err_q;
   logic [2:0]    err_d;
   logic [15:0]   cmd_cnt_q;
   logic          busy_q;
   logic          busy_d;

   logic          lo_valid_q;
   logic          lo_valid_d;
   logic [AW-1:0] lo_addr_q;
   logic [AW-1:0] lo_addr_d;
   logic [15:0]   lo_data_q;
   logic [15:0]   lo_data_d;

   logic          empty;
   logic          full;
   logic          pop;
   logic          push_ok;
   logic          ovf_ev;
   logic          seq_ev;
   logic          ill_ev;
   logic          clr_ev;
   cmd_t          head;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign pop     = (state_q == S_IDLE) && !empty;
   // A full FIFO still takes a push when the head leaves this cycle.
   assign push_ok = wen_dst && (!full || pop);
   assign ovf_ev  = wen_dst && full && !pop;
   assign head    = mem_q[rptr_q];
   assign cnt_d   = cnt_q + CW'(push_ok) - CW'(pop);

   always_comb begin
      state_d    = state_q;
      wr_valid_d = wr_valid_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      commit_d   = 1'b0;
      lo_valid_d = lo_valid_q;
      lo_addr_d  = lo_addr_q;
      lo_data_d  = lo_data_q;
      seq_ev     = 1'b0;
      ill_ev     = 1'b0;
      clr_ev     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (pop) begin
               unique case (1'b1)
                  (head.op == OP_NOP): begin
                  end
                  (head.op == OP_LO): begin
                     lo_valid_d = 1'b1;
                     lo_addr_d  = head.addr;
                     lo_data_d  = head.data;
                  end
                  (head.op == OP_HI): begin
                     lo_valid_d = 1'b0;
                     if (lo_valid_q && (head.addr == lo_addr_q)) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = head.addr;
                        wr_data_d  = {head.data, lo_data_q};
                        state_d    = S_ISSUE;
                     end else begin
                        seq_ev = 1'b1;
                     end
                  end
                  (head.op == OP_W16): begin
                     wr_valid_d = 1'b1;
                     wr_addr_d  = head.addr;
                     wr_data_d  = {16'h0000, head.data};
                     state_d    = S_ISSUE;
                  end
                  (head.op == OP_CMT): begin
                     commit_d = 1'b1;
                  end
                  (head.op == OP_CLR): begin
                     clr_ev = 1'b1;
                  end
                  default: begin
                     ill_ev = 1'b1;
                  end
               endcase
            end
         end
         S_ISSUE: begin
            if (wr.wr_ready) begin
               wr_valid_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Clear first so a same-cycle overflow still lands.
      err_d    = clr_ev ? 3'b000 : err_q;
      err_d[2] = err_d[2] | ovf_ev;
      err_d[1] = err_d[1] | seq_ev;
      err_d[0] = err_d[0] | ill_ev;

      busy_d = (cnt_d != '0) || (state_d != S_IDLE);
   end

   always_ff @(posedge dst_clk) begin
      if (push_ok) begin
         mem_q[wptr_q] <= cmd_t'(wdata_dst);
      end
   end

   always_ff @(posedge dst_clk or negedge dst_rst_n) begin
      if (!dst_rst_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         cmd_cnt_q  <= '0;
      end else begin
         if (push_ok) begin
            wptr_q    <= wptr_q + PW'(1);
            cmd_cnt_q <= cmd_cnt_q + 16'd1;
         end
         if (pop) begin
            rptr_q <= rptr_q + PW'(1);
         end
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge dst_clk or negedge dst_rst_n) begin
      if (!dst_rst_n) begin
         state_q    <= S_IDLE;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         commit_q   <= 1'b0;
         err_q      <= '0;
         busy_q     <= 1'b0;
         lo_valid_q <= 1'b0;
         lo_addr_q  <= '0;
         lo_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         commit_q   <= commit_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         lo_valid_q <= lo_valid_d;
         lo_addr_q  <= lo_addr_d;
         lo_data_q  <= lo_data_d;
      end
   end

   assign wr.wr_valid = wr_valid_q;
   assign wr.wr_addr  = wr_addr_q;
   assign wr.wr_data  = wr_data_q;
   assign commit      = commit_q;
   assign err_flags   = err_q;
   assign cmd_count   = cmd_cnt_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_gpio_cmd_decoder.sv
// Bench for gpio_cmd_decoder: directed scenarios plus random
// command bursts checked against a transaction-level model.
module tb_gpio_cmd_decoder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wen;
   logic [31:0] wdata;
   logic        commit;
   logic [2:0]  err;
   logic [15:0] cmd_count;
   logic        busy;

   int checks = 0;
   int errors = 0;

   gpio_cmd_decoder_if #(.AW(12)) wr_if ();

   gpio_cmd_decoder #(.DEPTH(DEPTH), .AW(12)) dut (
      .dst_clk   (clk),
      .dst_rst_n (rst_n),
      .wen_dst   (wen),
      .wdata_dst (wdata),
      .wr        (wr_if),
      .commit    (commit),
      .err_flags (err),
      .cmd_count (cmd_count),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   logic [43:0] act_q [$];
   int          commit_seen;

   always @(posedge clk) begin
      if (rst_n) begin
         if (wr_if.wr_valid && wr_if.wr_ready)
            act_q.push_back({wr_if.wr_addr, wr_if.wr_data});
         if (commit)
            commit_seen++;
      end
   end

   // Transaction-level reference model
   logic        m_lo_v;
   logic [11:0] m_lo_a;
   logic [15:0] m_lo_d;
   logic [2:0]  m_err;
   int          m_commits;
   int          m_pushes;
   logic [43:0] exp_q [$];

   task automatic model_reset();
      m_lo_v = 0; m_lo_a = 0; m_lo_d = 0;
      m_err = 0; m_commits = 0; m_pushes = 0;
      exp_q.delete();
   endtask

   task automatic model_apply(input logic [31:0] c);
      logic [3:0]  op;
      logic [11:0] a;
      logic [15:0] d;
      op = c[31:28]; a = c[27:16]; d = c[15:0];
      m_pushes++;
      case (op)
         4'h0: ;
         4'h1: begin m_lo_v = 1; m_lo_a = a; m_lo_d = d; end
         4'h2: begin
            if (m_lo_v && a == m_lo_a)
               exp_q.push_back({a, d, m_lo_d});
            else
               m_err[1] = 1'b1;
            m_lo_v = 0;
         end
         4'h3: exp_q.push_back({a, 16'h0000, d});
         4'h4: m_commits++;
         4'hF: m_err = 3'b000;
         default: m_err[0] = 1'b1;
      endcase
   endtask

   task automatic send(input logic [31:0] c);
      @(negedge clk);
      wen = 1'b1;
      wdata = c;
   endtask

   task automatic idle(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         wen = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      wen = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      act_q.delete();
      commit_seen = 0;
      model_reset();
   endtask

   task automatic test_reset();
      wr_if.wr_ready = 1'b1;
      do_reset();
      checks++;
      if ({wr_if.wr_valid, commit, busy} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctl: got %b want 000",
                  {wr_if.wr_valid, commit, busy});
      end
      checks++;
      if (wr_if.wr_addr !== 12'h000 || wr_if.wr_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_bus: got %h/%h want 0/0",
                  wr_if.wr_addr, wr_if.wr_data);
      end
      checks++;
      if (err !== 3'b000 || cmd_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %b/%0d want 000/0",
                  err, cmd_count);
      end
   endtask

   task automatic test_wr16();
      wr_if.wr_ready = 1'b1;
      act_q.delete();
      send(32'h30A5_1234);
      idle();
      checks++;
      if (wr_if.wr_valid !== 1'b0) begin
         errors++;
         $display("FAIL wr16_early: got %b want 0", wr_if.wr_valid);
      end
      idle();
      checks++;
      if (wr_if.wr_valid !== 1'b1 || wr_if.wr_addr !== 12'h0A5 ||
          wr_if.wr_data !== 32'h0000_1234) begin
         errors++;
         $display("FAIL wr16_issue: got %b %h %h want 1 0a5 00001234",
                  wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_data);
      end
      idle();
      checks++;
      if (wr_if.wr_valid !== 1'b0 || cmd_count !== 16'd1) begin
         errors++;
         $display("FAIL wr16_done: got %b cnt %0d want 0 cnt 1",
                  wr_if.wr_valid, cmd_count);
      end
      checks++;
      if (act_q.size() != 1 || act_q[0] !== {12'h0A5, 32'h1234}) begin
         errors++;
         $display("FAIL wr16_writes: got %0d writes want 1",
                  act_q.size());
      end
   endtask

   task automatic test_paired_stall();
      logic ok;
      wr_if.wr_ready = 1'b0;
      act_q.delete();
      send(32'h1010_BEEF);
      send(32'h2010_DEAD);
      idle(2);
      checks++;
      if (wr_if.wr_valid !== 1'b1 || wr_if.wr_addr !== 12'h010 ||
          wr_if.wr_data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL pair_issue: got %b %h %h want 1 010 deadbeef",
                  wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_data);
      end
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         idle();
         if (wr_if.wr_valid !== 1'b1 || wr_if.wr_addr !== 12'h010 ||
             wr_if.wr_data !== 32'hDEAD_BEEF)
            ok = 1'b0;
      end
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL pair_stable: got %b want 1", ok);
      end
      wr_if.wr_ready = 1'b1;
      idle(2);
      checks++;
      if (act_q.size() != 1 || act_q[0] !== {12'h010, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL pair_writes: got %0d writes want 1",
                  act_q.size());
      end
      checks++;
      if (wr_if.wr_valid !== 1'b0 || cmd_count !== 16'd3) begin
         errors++;
         $display("FAIL pair_done: got %b cnt %0d want 0 cnt 3",
                  wr_if.wr_valid, cmd_count);
      end
   endtask

   task automatic test_seq_errors();
      wr_if.wr_ready = 1'b1;
      act_q.delete();
      send(32'h2010_0000);
      idle(3);
      checks++;
      if (err !== 3'b010 || act_q.size() != 0) begin
         errors++;
         $display("FAIL seq_nolo: got %b/%0d want 010/0",
                  err, act_q.size());
      end
      send(32'hF000_0000);
      idle(2);
      checks++;
      if (err !== 3'b000) begin
         errors++;
         $display("FAIL seq_clr1: got %b want 000", err);
      end
      send(32'h1010_1111);
      send(32'h2011_2222);
      idle(3);
      checks++;
      if (err !== 3'b010 || act_q.size() != 0) begin
         errors++;
         $display("FAIL seq_addr: got %b/%0d want 010/0",
                  err, act_q.size());
      end
      send(32'hF000_0000);
      idle(2);
      checks++;
      if (err !== 3'b000) begin
         errors++;
         $display("FAIL seq_clr2: got %b want 000", err);
      end
   endtask

   task automatic test_overflow();
      bit drained;
      do_reset();
      wr_if.wr_ready = 1'b0;
      for (int i = 0; i <= DEPTH; i++)
         send({4'h3, 12'(i + 1), 16'(16'hA0 + i)});
      send(32'h3FFF_FFFF);
      idle();
      checks++;
      if (err !== 3'b100 || cmd_count !== 16'(DEPTH + 1)) begin
         errors++;
         $display("FAIL ovf_flag: got %b cnt %0d want 100 cnt %0d",
                  err, cmd_count, DEPTH + 1);
      end
      checks++;
      if (wr_if.wr_valid !== 1'b1 || wr_if.wr_addr !== 12'h001) begin
         errors++;
         $display("FAIL ovf_hold: got %b %h want 1 001",
                  wr_if.wr_valid, wr_if.wr_addr);
      end
      wr_if.wr_ready = 1'b1;
      drained = 0;
      for (int t = 0; t < 60 && !drained; t++) begin
         idle();
         if (!busy) drained = 1;
      end
      idle();
      checks++;
      if (!drained) begin
         errors++;
         $display("FAIL ovf_drain: busy %b want 0 within 60", busy);
      end
      checks++;
      if (act_q.size() != DEPTH + 1) begin
         errors++;
         $display("FAIL ovf_count: got %0d writes want %0d",
                  act_q.size(), DEPTH + 1);
      end
      for (int i = 0; i <= DEPTH && i < act_q.size(); i++) begin
         checks++;
         if (act_q[i] !== {12'(i + 1), 16'h0000, 16'(16'hA0 + i)}) begin
            errors++;
            $display("FAIL ovf_order%0d: got %h want %h", i, act_q[i],
                     {12'(i + 1), 16'h0000, 16'(16'hA0 + i)});
         end
      end
   endtask

   task automatic test_commit_illegal();
      wr_if.wr_ready = 1'b1;
      send(32'hF000_0000);
      idle(2);
      commit_seen = 0;
      send(32'h4000_0000);
      idle();
      checks++;
      if (commit !== 1'b0) begin
         errors++;
         $display("FAIL cmt_early: got %b want 0", commit);
      end
      idle();
      checks++;
      if (commit !== 1'b1) begin
         errors++;
         $display("FAIL cmt_pulse: got %b want 1", commit);
      end
      idle();
      checks++;
      if (commit !== 1'b0 || commit_seen != 1) begin
         errors++;
         $display("FAIL cmt_width: got %b seen %0d want 0 seen 1",
                  commit, commit_seen);
      end
      act_q.delete();
      send(32'h7123_4567);
      idle(3);
      checks++;
      if (err !== 3'b001) begin
         errors++;
         $display("FAIL ill_flag: got %b want 001", err);
      end
      checks++;
      if (wr_if.wr_valid !== 1'b0 || wr_if.wr_addr !== 12'h005 ||
          wr_if.wr_data !== 32'h0000_00A4 || commit !== 1'b0 ||
          act_q.size() != 0) begin
         errors++;
         $display("FAIL ill_quiet: got %b %h %h %b %0d want 0 005 000000a4 0 0",
                  wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_data,
                  commit, act_q.size());
      end
   endtask

   task automatic test_reset_mid();
      wr_if.wr_ready = 1'b0;
      send(32'h3001_0001);
      send(32'h3002_0002);
      send(32'h3003_0003);
      idle();
      checks++;
      if (wr_if.wr_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre: got %b %b want 1 1",
                  wr_if.wr_valid, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({wr_if.wr_valid, commit, busy, err} !== 6'b0 ||
          wr_if.wr_addr !== 12'h0 || wr_if.wr_data !== 32'h0 ||
          cmd_count !== 16'h0) begin
         errors++;
         $display("FAIL rst_async: got %b %b %b %b %h %h %0d want zeros",
                  wr_if.wr_valid, commit, busy, err,
                  wr_if.wr_addr, wr_if.wr_data, cmd_count);
      end
      wr_if.wr_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      act_q.delete();
      idle(8);
      checks++;
      if (act_q.size() != 0 || busy !== 1'b0 || wr_if.wr_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_stale: got %0d writes busy %b want 0 busy 0",
                  act_q.size(), busy);
      end
   endtask

   task automatic test_random();
      logic [31:0] c;
      logic [3:0]  op;
      int          n;
      bit          drained;
      do_reset();
      for (int it = 0; it < 60; it++) begin
         n = $urandom_range(1, DEPTH);
         for (int j = 0; j < n; j++) begin
            case ($urandom_range(0, 9))
               0:       op = 4'h0;
               1, 2:    op = 4'h1;
               3, 4:    op = 4'h2;
               5, 9:    op = 4'h3;
               6:       op = 4'h4;
               7:       op = 4'hF;
               default: op = 4'($urandom_range(5, 14));
            endcase
            c = {op, 12'($urandom_range(0, 3)), 16'($urandom)};
            wr_if.wr_ready = 1'($urandom_range(0, 1));
            send(c);
            model_apply(c);
         end
         idle();
         drained = 0;
         for (int t = 0; t < 120 && !drained; t++) begin
            wr_if.wr_ready = 1'($urandom_range(0, 1));
            idle();
            if (!busy) drained = 1;
         end
         idle();
         checks++;
         if (!drained || act_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rnd_len%0d: drained %b got %0d want %0d",
                     it, drained, act_q.size(), exp_q.size());
         end
         for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            checks++;
            if (act_q[k] !== exp_q[k]) begin
               errors++;
               $display("FAIL rnd_wr%0d_%0d: got %h want %h",
                        it, k, act_q[k], exp_q[k]);
            end
         end
         act_q.delete();
         exp_q.delete();
      end
      checks++;
      if (commit_seen != m_commits) begin
         errors++;
         $display("FAIL rnd_commits: got %0d want %0d",
                  commit_seen, m_commits);
      end
      checks++;
      if (err !== m_err) begin
         errors++;
         $display("FAIL rnd_err: got %b want %b", err, m_err);
      end
      checks++;
      if (cmd_count !== 16'(m_pushes)) begin
         errors++;
         $display("FAIL rnd_cmdcnt: got %0d want %0d",
                  cmd_count, m_pushes);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      wen = 1'b0;
      wdata = '0;
      wr_if.wr_ready = 1'b0;
      commit_seen = 0;
      model_reset();
      test_reset();
      test_wr16();
      test_paired_stall();
      test_seq_errors();
      test_overflow();
      test_commit_illegal();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
